// File: rtl/e_card_detect_ctrl.sv
// Card-detect / write-protect synchronizer, insertion debounce FSM and
// socket power sequencer with power-good delay for the SD host controller.
module e_card_detect_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int PON_DELAY       = 250,
    parameter bit CD_ACTIVE_LOW   = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sd_pon,
    input  logic i_cd,
    input  logic i_wp,
    output logic o_pon,
    output logic o_pwr_good,
    output logic o_cd_level,
    output logic o_wp_level,
    output logic o_card_stable,
    output logic o_card_inserted,
    output logic o_ins_evt,
    output logic o_rem_evt
);

    localparam int MAXP = (DEBOUNCE_CYCLES > PON_DELAY) ? DEBOUNCE_CYCLES : PON_DELAY;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] PON_MAX  = CW'(PON_DELAY);

    localparam logic [1:0] S_NO_CARD = 2'd0;
    localparam logic [1:0] S_DEB_IN  = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DEB_OUT = 2'd3;

    logic          r_cd_s1, r_cd_s2, r_wp_s1, r_wp_s2;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_pwr_cnt;
    logic          r_inserted, r_stable, r_ins_evt, r_rem_evt, r_pon;

    logic          w_present;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ins_nxt, w_rem_nxt, w_inserted_nxt, w_stable_nxt, w_pon_nxt;

    // Sync flops come out of reset at the card-absent level so no false insertion is seen
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cd_s1 <= CD_ACTIVE_LOW;
            r_cd_s2 <= CD_ACTIVE_LOW;
            r_wp_s1 <= 1'b1;
            r_wp_s2 <= 1'b1;
        end else begin
            r_cd_s1 <= i_cd;
            r_cd_s2 <= r_cd_s1;
            r_wp_s1 <= i_wp;
            r_wp_s2 <= r_wp_s1;
        end
    end

    assign w_present = r_cd_s2 ^ CD_ACTIVE_LOW;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ins_nxt   = 1'b0;
        w_rem_nxt   = 1'b0;
        case (r_state)
            S_NO_CARD: if (w_present) begin
                w_state_nxt = S_DEB_IN;
                w_cnt_nxt   = '0;
            end
            S_DEB_IN: begin
                if (!w_present) begin
                    w_state_nxt = S_NO_CARD;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = S_PRESENT;
                    w_ins_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PRESENT: if (!w_present) begin
                w_state_nxt = S_DEB_OUT;
                w_cnt_nxt   = '0;
            end
            default: begin
                if (w_present) begin
                    w_state_nxt = S_PRESENT;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = S_NO_CARD;
                    w_rem_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    // Outputs are derived from the next state so they line up with the state register
    assign w_inserted_nxt = (w_state_nxt == S_PRESENT) || (w_state_nxt == S_DEB_OUT);
    assign w_stable_nxt   = !((w_state_nxt == S_DEB_IN) || (w_state_nxt == S_DEB_OUT));
    assign w_pon_nxt      = i_sd_pon & w_inserted_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_NO_CARD;
            r_cnt      <= '0;
            r_inserted <= 1'b0;
            r_stable   <= 1'b1;
            r_ins_evt  <= 1'b0;
            r_rem_evt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_inserted <= w_inserted_nxt;
            r_stable   <= w_stable_nxt;
            r_ins_evt  <= w_ins_nxt;
            r_rem_evt  <= w_rem_nxt;
        end
    end

    // pwr_cnt clears on the edge pon falls, so pwr_good drops together with pon
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pon     <= 1'b0;
            r_pwr_cnt <= '0;
        end else begin
            r_pon <= w_pon_nxt;
            if (!w_pon_nxt)
                r_pwr_cnt <= '0;
            else if (r_pon && (r_pwr_cnt != PON_MAX))
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
        end
    end

    assign o_pon           = r_pon;
    assign o_pwr_good      = (r_pwr_cnt == PON_MAX);
    assign o_cd_level      = r_cd_s2;
    assign o_wp_level      = r_wp_s2;
    assign o_card_stable   = r_stable;
    assign o_card_inserted = r_inserted;
    assign o_ins_evt       = r_ins_evt;
    assign o_rem_evt       = r_rem_evt;

endmodule

// File: tb/tb_e_card_detect_ctrl.sv
// Table-driven scoreboard bench for e_card_detect_ctrl (DEBOUNCE=4, PON_DELAY=8, active-low CD).
module tb_e_card_detect_ctrl;

    logic clk = 1'b0;
    logic rst, sd_pon, cd, wp;
    logic pon, pwr_good, cd_level, wp_level, card_stable, card_inserted, ins_evt, rem_evt;

    int checks   = 0;
    int failures = 0;
    int row      = 0;

    typedef struct {
        logic       cd;
        logic       wp;
        logic       sp;
        logic [7:0] exp;  // {cd_level, wp_level, stable, inserted, ins_evt, rem_evt, pon, pwr_good}
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    e_card_detect_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PON_DELAY(8),
        .CD_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_sd_pon(sd_pon),
        .i_cd(cd),
        .i_wp(wp),
        .o_pon(pon),
        .o_pwr_good(pwr_good),
        .o_cd_level(cd_level),
        .o_wp_level(wp_level),
        .o_card_stable(card_stable),
        .o_card_inserted(card_inserted),
        .o_ins_evt(ins_evt),
        .o_rem_evt(rem_evt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {cd_level, wp_level, card_stable, card_inserted, ins_evt, rem_evt, pon, pwr_good};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b (cdl wpl stb ins ievt revt pon pg)", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic w, input logic s, input logic [7:0] e);
        vec_t v;
        v.cd = c; v.wp = w; v.sp = s; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step(input logic c, input logic w, input logic s, input logic [7:0] e);
        logic [7:0] want;
        cd = c; wp = w; sd_pon = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        row++;
        check($sformatf("row%0d", row), outs(), want);
    endtask

    initial begin
        rst = 1'b1; cd = 1'b1; wp = 1'b1; sd_pon = 1'b0;

        // Idle, no card
        repeat (2) add(1, 1, 0, 8'b1110_0000);
        // Insertion with wp released
        add(0, 0, 0, 8'b1110_0000);
        add(0, 0, 0, 8'b0010_0000);
        repeat (4) add(0, 0, 0, 8'b0000_0000);
        add(0, 0, 0, 8'b0011_1000);
        add(0, 0, 0, 8'b0011_0000);
        // Power request: pon next edge, pwr_good 8 edges later, saturated
        repeat (8) add(0, 0, 1, 8'b0011_0010);
        repeat (2) add(0, 0, 1, 8'b0011_0011);
        // Power request dropped
        add(0, 0, 0, 8'b0011_0000);
        add(0, 0, 1, 8'b0011_0010);
        // Removal with sd_pon held: rem_evt and pon drop together
        add(1, 0, 1, 8'b0011_0010);
        add(1, 0, 1, 8'b1011_0010);
        repeat (4) add(1, 0, 1, 8'b1001_0010);
        add(1, 0, 1, 8'b1010_0100);
        add(1, 0, 1, 8'b1010_0000);
        // Insertion with sd_pon already high powers up automatically
        add(0, 1, 1, 8'b1010_0000);
        add(0, 1, 1, 8'b0110_0000);
        repeat (4) add(0, 1, 1, 8'b0100_0000);
        add(0, 1, 1, 8'b0111_1010);
        add(0, 1, 1, 8'b0111_0010);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 8'b1110_0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].cd, vecs[i].wp, vecs[i].sp, vecs[i].exp);

        // Start a removal, then reset asynchronously while pon is high
        step(1, 1, 1, 8'b0111_0010);
        step(1, 1, 1, 8'b1111_0010);
        step(1, 1, 1, 8'b1101_0010);
        rst = 1'b1;
        #2;
        check("async_rst", outs(), 8'b1110_0000);
        sd_pon = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held", outs(), 8'b1110_0000);
        rst = 1'b0;

        // Glitch: cd low for two cycles aborts the insertion debounce
        step(0, 1, 0, 8'b1110_0000);
        step(0, 1, 0, 8'b0110_0000);
        step(1, 1, 0, 8'b0100_0000);
        step(1, 1, 0, 8'b1100_0000);
        repeat (6) step(1, 1, 0, 8'b1110_0000);

        // Fresh insertion after the glitch takes the full debounce again
        step(0, 1, 0, 8'b1110_0000);
        step(0, 1, 0, 8'b0110_0000);
        repeat (4) step(0, 1, 0, 8'b0100_0000);
        step(0, 1, 0, 8'b0111_1000);
        step(0, 1, 0, 8'b0111_0000);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got=%0d left expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
